// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS PC/instruction trace capture logic.
// Holds the drop-counter width, the entry-width helper and the full-buffer policy encodings.
package mips_trace_pkg;

  localparam int DROP_W = 16;

  typedef enum logic {
    TRACE_STOP = 1'b0,
    TRACE_CIRC = 1'b1
  } trace_wrap_e;

  function automatic int entry_w(input int addr_w, input int instr_w);
    return addr_w + instr_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, asynchronous read.
// The array has no reset; validity is tracked by the owner's count.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pc_trace_buffer.sv
// PC/instruction trace capture FIFO (first-word fall-through) with optional de-duplication,
// selectable stop/circular full policy, sticky overflow flag and saturating drop counter.
module pc_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int WRAP    = 0,
  parameter int DEDUP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_en,
  input  logic                       clr,
  input  logic                       tr_valid,
  input  logic [ADDR_W-1:0]          tr_pc,
  input  logic [INSTR_W-1:0]         tr_ir,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [INSTR_W-1:0]         rd_ir,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_w(ADDR_W, INSTR_W);
  localparam trace_wrap_e POLICY = (WRAP != 0) ? TRACE_CIRC : TRACE_STOP;

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  last_pc;
  logic [INSTR_W-1:0] last_ir;
  logic               last_vld;
  logic               qual, changed, push, pop, full, drop, wr_en, rd_adv, inc, dec;
  logic [EW-1:0]      head;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({tr_pc, tr_ir}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign rd_valid = (count != '0);

  // A circular-mode push into a full buffer writes over the head slot and moves both pointers.
  always_comb begin
    qual    = cap_en & tr_valid;
    changed = (DEDUP == 0) || !last_vld || (tr_pc != last_pc) || (tr_ir != last_ir);
    push    = qual & changed;
    pop     = rd_valid & rd_ready;
    full    = (count == CW'(DEPTH));
    drop    = push & full & ~pop;
    wr_en   = push & ~clr & (~full | pop | (POLICY == TRACE_CIRC));
    rd_adv  = pop | (wr_en & full);
    inc     = wr_en & ~full & ~pop;
    dec     = pop & ~wr_en;
  end

  always_comb begin
    rd_pc = '0;
    rd_ir = '0;
    if (rd_valid) begin
      rd_pc = head[EW-1:INSTR_W];
      rd_ir = head[INSTR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      last_pc  <= '0;
      last_ir  <= '0;
      last_vld <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      last_vld <= 1'b0;
    end else begin
      if (qual) begin
        last_pc  <= tr_pc;
        last_ir  <= tr_ir;
        last_vld <= 1'b1;
      end
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      if (inc)      count <= count + CW'(1);
      else if (dec) count <= count - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: two DEPTH=4 instances (stop and circular) share one stimulus.
module tb_pc_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, cap_en, clr, tr_valid, rd_ready;
  logic [31:0] tr_pc, tr_ir;

  logic        s_valid, c_valid, s_ovf, c_ovf;
  logic [31:0] s_pc, s_ir, c_pc, c_ir;
  logic [2:0]  s_cnt, c_cnt;
  logic [15:0] s_drop, c_drop;

  logic [31:0] spc [13];
  logic [31:0] sir [13];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_trace_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .WRAP(0), .DEDUP(1)) u_stop (
    .clk(clk), .rst(rst), .cap_en(cap_en), .clr(clr), .tr_valid(tr_valid),
    .tr_pc(tr_pc), .tr_ir(tr_ir), .rd_valid(s_valid), .rd_ready(rd_ready),
    .rd_pc(s_pc), .rd_ir(s_ir), .count(s_cnt), .overflow(s_ovf), .drop_cnt(s_drop)
  );

  pc_trace_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .WRAP(1), .DEDUP(1)) u_circ (
    .clk(clk), .rst(rst), .cap_en(cap_en), .clr(clr), .tr_valid(tr_valid),
    .tr_pc(tr_pc), .tr_ir(tr_ir), .rd_valid(c_valid), .rd_ready(rd_ready),
    .rd_pc(c_pc), .rd_ir(c_ir), .count(c_cnt), .overflow(c_ovf), .drop_cnt(c_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir, input logic rdy);
    tr_valid = v;
    tr_pc    = pc;
    tr_ir    = ir;
    rd_ready = rdy;
  endtask

  task automatic chk_both(input string tag, input int cnt, input int drp, input logic ovf);
    chk({tag, " stop count"}, 64'(s_cnt), 64'(cnt));
    chk({tag, " circ count"}, 64'(c_cnt), 64'(cnt));
    chk({tag, " stop drop"}, 64'(s_drop), 64'(drp));
    chk({tag, " circ drop"}, 64'(c_drop), 64'(drp));
    chk({tag, " stop ovf"}, 64'(s_ovf), 64'(ovf));
    chk({tag, " circ ovf"}, 64'(c_ovf), 64'(ovf));
  endtask

  int s_exp [4] = '{1, 2, 3, 6};
  int c_exp [4] = '{3, 4, 5, 6};

  initial begin
    for (int i = 0; i < 13; i++) begin
      spc[i] = 32'h0000_0100 + 32'(4 * i);
      sir[i] = 32'hA000_0000 + 32'(i);
    end
    rst = 1'b0; cap_en = 1'b1; clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("reset valid", 64'({s_valid, c_valid}), 64'(0));
    chk("reset rd_pc", 64'(s_pc), 64'(0));
    chk_both("reset", 0, 0, 1'b0);
    tick();
    rst = 1'b1;

    // de-duplication: three identical samples then a new one
    drive(1'b1, 32'h0000_3000, 32'h2008_0005, 1'b0);
    tick();
    chk("first push count", 64'(s_cnt), 64'(1));
    chk("first push head pc", 64'(s_pc), 64'h3000);
    tick(); tick();
    drive(1'b1, 32'h0000_3004, 32'h2009_000A, 1'b0);
    tick();
    chk_both("dedup", 2, 0, 1'b0);
    chk("dedup head ir", 64'(s_ir), 64'h2008_0005);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk("dedup 2nd pc", 64'(c_pc), 64'h3004);
    chk("dedup 2nd ir", 64'(c_ir), 64'h2009_000A);
    tick();
    chk("dedup drained valid", 64'({s_valid, c_valid}), 64'(0));
    chk("dedup drained rd_ir", 64'(s_ir), 64'(0));

    // six distinct samples into a four-deep buffer, no draining
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, spc[i], sir[i], 1'b0);
      tick();
    end
    chk_both("fill6", 4, 2, 1'b1);
    chk("stop head", 64'(s_pc), 64'(spc[0]));
    chk("circ head", 64'(c_pc), 64'(spc[2]));

    // full buffer, push and pop together
    drive(1'b1, spc[6], sir[6], 1'b1);
    tick();
    chk_both("push+pop full", 4, 2, 1'b1);
    chk("stop head after pp", 64'(s_ir), 64'(sir[1]));
    chk("circ head after pp", 64'(c_ir), 64'(sir[3]));

    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stop drain %0d", i), 64'({s_pc, s_ir}), {spc[s_exp[i]], sir[s_exp[i]]});
      chk($sformatf("circ drain %0d", i), 64'({c_pc, c_ir}), {spc[c_exp[i]], sir[c_exp[i]]});
      tick();
    end
    chk("drain empty count", 64'({s_cnt, c_cnt}), 64'(0));

    // cap_en=0 must neither store nor update the last-sample registers
    cap_en = 1'b0;
    drive(1'b1, spc[7], sir[7], 1'b0);
    tick();
    chk("cap_en off count", 64'(s_cnt), 64'(0));
    cap_en = 1'b1;
    drive(1'b1, spc[6], sir[6], 1'b0);
    tick();
    chk("repeat after freeze", 64'({s_cnt, c_cnt}), 64'(0));

    for (int i = 8; i < 11; i++) begin
      drive(1'b1, spc[i], sir[i], 1'b0);
      tick();
    end
    chk("pre-clr count", 64'(s_cnt), 64'(3));
    chk("pre-clr ovf", 64'({s_ovf, c_ovf}), 64'(3));
    clr = 1'b1;
    drive(1'b1, spc[10], sir[10], 1'b1);
    tick();
    chk_both("clr", 0, 0, 1'b0);
    chk("clr valid", 64'({s_valid, c_valid}), 64'(0));
    clr = 1'b0;
    drive(1'b1, spc[10], sir[10], 1'b0);
    tick();
    chk("post-clr repeat count", 64'(c_cnt), 64'(1));
    chk("post-clr repeat head", 64'({c_pc, c_ir}), {spc[10], sir[10]});

    for (int i = 11; i < 13; i++) begin
      drive(1'b1, spc[i], sir[i], 1'b0);
      tick();
    end
    chk("pre-rst count", 64'(s_cnt), 64'(3));
    drive(1'b0, '0, '0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst count", 64'({s_cnt, c_cnt}), 64'(0));
    chk("async rst valid", 64'({s_valid, c_valid}), 64'(0));
    chk("async rst rd_pc", 64'({s_pc, c_pc}), 64'(0));
    chk("async rst rd_ir", 64'({s_ir, c_ir}), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("after rst count", 64'(s_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
